// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Types and default constants shared by the instruction fetch unit, its
// interface, and the instruction memory.
//   fetch_state_t     : fetch controller state {FETCH, HALT, FAULT}
//   DEFAULT_ADDR_W    : word-address width of the instruction memory
//   DEFAULT_DATA_W    : instruction width
//   DEFAULT_RESET_PC  : PC value after reset
//   DEFAULT_HALT_WORD : instruction encoding that stops fetch
// ---------------------------------------------------------------------------
package ifetch_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC  = 16'h0000;
    localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the instruction-memory read port, the decode handshake and the
// control-flow/status signals of the fetch unit.
//   master : fetch unit side (drives address, ir, status)
//   slave  : memory + decode side (drives read data, ready, redirect)
// Signals:
//   inst_address  word address to instruction memory
//   read_data     combinational memory word for inst_address
//   ir, ir_pc     captured instruction and the address it came from
//   ir_valid      ir holds an untaken instruction
//   ir_ready      decode accepts ir
//   redirect      one-cycle PC load request, target in redirect_pc
//   halted, fault fetch status
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;
    logic              fault;

    modport master (
        output inst_address, ir, ir_pc, ir_valid, halted, fault,
        input  read_data, ir_ready, redirect, redirect_pc
    );

    modport slave (
        input  inst_address, ir, ir_pc, ir_valid, halted, fault,
        output read_data, ir_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifetch_ir_buf.sv
// ---------------------------------------------------------------------------
// ifetch_ir_buf
// Single-entry instruction register toward decode with valid/ready handshake.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              capture data_in/pc_in and mark valid
//   flush             drop the held entry (wins over load)
//   data_in, pc_in    word and its fetch address
//   ir_ready          decode accepts the entry this cycle
//   ir, ir_pc         held word and address
//   ir_valid          entry is valid
//   slot_free         entry is empty or being consumed this cycle
// ---------------------------------------------------------------------------
module ifetch_ir_buf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              slot_free
);

    assign slot_free = !ir_valid || ir_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (flush) begin
            ir_valid <= 1'b0;
        end else if (load) begin
            ir       <= data_in;
            ir_pc    <= pc_in;
            ir_valid <= 1'b1;
        end else if (ir_valid && ir_ready) begin
            // last word handed over and nothing new captured (halt)
            ir_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Owns the program counter, reads the combinational instruction memory and
// hands words to decode through ifetch_ir_buf. Handles redirects and halt.
// Optional macro IFETCH_BOUND_CHECK_EN: fetching from pc >= MEM_DEPTH stops
// fetch and raises fault instead of presenting the word.
// Ports:
//   clk    rising-edge clock
//   rst_n  async active-low reset
//   bus    instruction_fetch_unit_if.master (memory port, decode handshake,
//          redirect, halted/fault status)
//
// state | meaning
// ------+------------------------------------------------------------
// FETCH | fetching one word per free ir slot, pc advancing
// HALT  | HALT_WORD captured, pc frozen, no more fetches
// FAULT | fetch attempted out of range, waiting for redirect/reset
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned       MEM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [DATA_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input logic                       clk,
    input logic                       rst_n,
    instruction_fetch_unit_if.master  bus
);

`ifdef IFETCH_BOUND_CHECK_EN
    localparam bit BOUND_CHECK = 1'b1;
`else
    localparam bit BOUND_CHECK = 1'b0;
`endif

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              halted_q;
    logic              fault_q;

    logic slot_free;
    logic in_range;
    logic fetch_slot;
    logic fault_hit;
    logic load;
    logic flush;
    logic is_halt;

    assign in_range   = 32'(pc) < MEM_DEPTH;
    // a redirect on this edge suppresses the fetch; the new pc fetches next edge
    assign fetch_slot = (state == FETCH) && slot_free && !bus.redirect;
    assign fault_hit  = BOUND_CHECK && fetch_slot && !in_range;
    assign load       = fetch_slot && !fault_hit;
    assign flush      = bus.redirect || fault_hit;
    assign is_halt    = (bus.read_data == HALT_WORD);

    assign bus.inst_address = pc;
    assign bus.halted       = halted_q;
    assign bus.fault        = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (bus.redirect) begin
            state    <= FETCH;
            pc       <= bus.redirect_pc;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fault_hit) begin
                        state   <= FAULT;
                        fault_q <= 1'b1;
                    end else if (load) begin
                        if (is_halt) begin
                            // pc stays on the halt word's address
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end
                HALT:    ;
                FAULT:   ;
                default: state <= FETCH;
            endcase
        end
    end

    ifetch_ir_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ir_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .data_in   (bus.read_data),
        .pc_in     (pc),
        .ir_ready  (bus.ir_ready),
        .ir        (bus.ir),
        .ir_pc     (bus.ir_pc),
        .ir_valid  (bus.ir_valid),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit with a behavioural reference
// model checked every cycle plus literal spot checks.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

`ifdef IFETCH_BOUND_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    instruction_fetch_unit_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    instruction_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory contents
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'd0)       return 32'h2000_0000;
        else if (a < 16'd5)   return {16'h0000, a};
        else if (a == 16'd5)  return HALTW;
        else if (a < 16'd256) return {16'h1000, a};
        else                  return {16'hBAD0, a};
    endfunction

    assign bus.read_data = mem_word(bus.inst_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: what the fetch unit must hold after each edge
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    logic [15:0] m_ir_pc;
    logic        m_valid, m_halted, m_fault;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] w;
        if (!rst_n) begin
            m_pc = 16'h0000; m_ir = '0; m_ir_pc = '0;
            m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        end else if (bus.redirect) begin
            m_pc = bus.redirect_pc;
            m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        end else if (!m_halted && !m_fault && (!m_valid || bus.ir_ready)) begin
            if (BC && m_pc >= 16'd256) begin
                m_fault = 1'b1;
                m_valid = 1'b0;
            end else begin
                w = mem_word(m_pc);
                m_ir = w; m_ir_pc = m_pc; m_valid = 1'b1;
                if (w == HALTW) m_halted = 1'b1;
                else            m_pc = m_pc + 16'd1;
            end
        end else if (m_valid && bus.ir_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model inst_address", 32'(bus.inst_address), 32'(m_pc));
            chk("model ir_valid", 32'(bus.ir_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model ir", bus.ir, m_ir);
                chk("model ir_pc", 32'(bus.ir_pc), 32'(m_ir_pc));
            end
            chk("model halted", 32'(bus.halted), 32'(m_halted));
            chk("model fault", 32'(bus.fault), 32'(m_fault));
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.ir_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        chk("reset inst_address", 32'(bus.inst_address), 32'h0);
        chk("reset ir_valid", 32'(bus.ir_valid), 32'h0);
        chk("reset ir", bus.ir, 32'h0);
        chk("reset halted", 32'(bus.halted), 32'h0);
        rst_n = 1'b1;

        // streaming from 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream ir_pc", 32'(bus.ir_pc), 32'(i));
        end
        chk("stream ir word3", bus.ir, 32'h0000_0003);
        repeat (2) @(negedge clk);
        chk("halt ir", bus.ir, 32'hFFFF_FFFF);
        chk("halt halted", 32'(bus.halted), 32'h1);
        chk("halt ir_valid", 32'(bus.ir_valid), 32'h1);
        chk("halt inst_address", 32'(bus.inst_address), 32'h5);
        repeat (2) @(negedge clk);
        chk("halt addr frozen", 32'(bus.inst_address), 32'h5);
        chk("halt valid dropped", 32'(bus.ir_valid), 32'h0);

        // redirect out of halt, then backpressure
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0000; bus.ir_ready = 1'b0;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("unhalt halted", 32'(bus.halted), 32'h0);
        chk("unhalt ir_valid", 32'(bus.ir_valid), 32'h0);
        @(negedge clk);
        chk("refetch ir_pc", 32'(bus.ir_pc), 32'h0);
        chk("refetch ir", bus.ir, 32'h2000_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp ir", bus.ir, 32'h2000_0000);
            chk("bp ir_pc", 32'(bus.ir_pc), 32'h0);
            chk("bp pc", 32'(bus.inst_address), 32'h1);
        end
        bus.ir_ready = 1'b1;
        @(negedge clk);
        chk("bp resume ir_pc", 32'(bus.ir_pc), 32'h1);

        // redirect coinciding with a handshake
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("redir flush", 32'(bus.ir_valid), 32'h0);
        chk("redir pc", 32'(bus.inst_address), 32'h40);
        @(negedge clk);
        chk("redir ir_pc", 32'(bus.ir_pc), 32'h40);
        chk("redir ir", bus.ir, 32'h1000_0040);
        @(negedge clk);
        chk("redir next", 32'(bus.ir_pc), 32'h41);

        // redirect while stalled
        bus.ir_ready = 1'b0;
        @(negedge clk);
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0080;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("stall redir flush", 32'(bus.ir_valid), 32'h0);
        @(negedge clk);
        chk("stall redir ir_pc", 32'(bus.ir_pc), 32'h80);
        bus.ir_ready = 1'b1;

`ifdef IFETCH_BOUND_CHECK_EN
        bus.redirect = 1'b1; bus.redirect_pc = 16'd256;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("oob flush", 32'(bus.ir_valid), 32'h0);
        @(negedge clk);
        chk("oob fault", 32'(bus.fault), 32'h1);
        chk("oob valid", 32'(bus.ir_valid), 32'h0);
        repeat (2) @(negedge clk);
        chk("oob fault held", 32'(bus.fault), 32'h1);
        chk("oob pc held", 32'(bus.inst_address), 32'd256);
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0000;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("oob cleared", 32'(bus.fault), 32'h0);
        @(negedge clk);
        chk("oob refetch", 32'(bus.ir_pc), 32'h0);
`else
        bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF;
        @(negedge clk);
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("wrap ir_pc", 32'(bus.ir_pc), 32'h0000_FFFF);
        chk("wrap ir", bus.ir, 32'hBAD0_FFFF);
        chk("wrap pc", 32'(bus.inst_address), 32'h0);
        chk("wrap fault", 32'(bus.fault), 32'h0);
        @(negedge clk);
        chk("wrap next", 32'(bus.ir_pc), 32'h0);
`endif

        // async reset mid-stream
        @(negedge clk);
        chk("pre-rst valid", 32'(bus.ir_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst inst_address", 32'(bus.inst_address), 32'h0);
        chk("arst ir", bus.ir, 32'h0);
        chk("arst ir_pc", 32'(bus.ir_pc), 32'h0);
        chk("arst ir_valid", 32'(bus.ir_valid), 32'h0);
        chk("arst halted", 32'(bus.halted), 32'h0);
        chk("arst fault", 32'(bus.fault), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post-rst ir_pc", 32'(bus.ir_pc), 32'h2);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Initiator side of the instruction-memory read port in the multicycle CPU. It owns the program counter and drives the word address to the combinational instruction memory. It captures the returned 32-bit word into an instruction register and hands it to the decode stage over a valid/ready handshake. It also handles control-flow redirects, halt detection and, optionally, out-of-range fetch faults.

## Interface
- ADDR_W, 16, word-address width; matches the memory's inst_address.
- DATA_W, 32, instruction width.
- MEM_DEPTH, 256, number of implemented instruction words.
- RESET_PC, 16'h0000, PC value after reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_address  out  ADDR_W  word address to the instruction memory; equals the pc register.
- read_data  in  DATA_W  instruction word from memory; combinational, valid in the same cycle.
- ir  out  DATA_W  captured instruction.
- ir_pc  out  ADDR_W  address the word in ir was fetched from.
- ir_valid  out  1  ir holds an untaken instruction.
- ir_ready  in  1  decode accepts ir when high together with ir_valid.
- redirect  in  1  one-cycle pulse requesting a PC load.
- redirect_pc  in  ADDR_W  target address, sampled while redirect is high.
- halted  out  1  fetch stopped on HALT_WORD.
- fault  out  1  out-of-range fetch; held at 0 when the feature is compiled out.

## Operation
- FSM states: FETCH, HALT, FAULT. Reset state is FETCH.
- In FETCH, a fetch occurs when `!ir_valid || ir_ready`:
  - ir is loaded from read_data, ir_pc from pc, and ir_valid is set to 1.
  - pc is loaded with pc+1, modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
- Backpressure: when ir_valid is high and ir_ready is low, ir, ir_pc and pc all hold.
- Halt: if the fetched word equals HALT_WORD, it is still presented normally on ir.
  - The unit enters HALT and halted goes to 1. pc is not incremented.
  - No further fetches occur. ir_valid drops after decode accepts the word.
- Redirect has the highest priority in every state:
  - pc is loaded with redirect_pc and ir_valid is cleared (flush).
  - The state returns to FETCH, and halted and fault are cleared.
- Redirect and handshake on the same edge: the transfer counts as completed and the flush still applies. No fetch happens on that edge.
- Reset values: pc = RESET_PC, inst_address = RESET_PC, ir = 0, ir_pc = 0, ir_valid = 0, halted = 0, fault = 0.
- Reset mid-operation: all state clears asynchronously. Any pending ir is discarded.

## Timing
- Memory path: inst_address → read_data is combinational, so the word for pc is captured on the same edge that advances pc.
- Throughput: one instruction per cycle while ir_ready is held high.
- Redirect latency: redirect is sampled at edge E. ir_valid is 0 after E. The word at redirect_pc is in ir, with ir_valid = 1, after edge E+1.
- Halt: halted rises after the edge that captures HALT_WORD, in the same cycle that ir_valid shows that word.
- The outputs ir, ir_pc, ir_valid, halted and fault are all registered. inst_address is pc, with no combinational path from any input.

## Configuration
- IFETCH_BOUND_CHECK_EN defined:
  - In FETCH, when pc >= MEM_DEPTH and a fetch would occur, no capture happens and ir_valid is cleared.
  - The state goes to FAULT and fault becomes 1.
  - Only a redirect or reset leaves FAULT.
- IFETCH_BOUND_CHECK_EN undefined: there is no range check, fault is tied to 0, the FAULT state is unreachable, and any pc is presented to the memory.

## Structure
- Shared package ifetch_pkg holds:
  - the fetch_state_t enum {FETCH, HALT, FAULT};
  - the constants DEFAULT_RESET_PC and DEFAULT_HALT_WORD;
  - the ADDR_W and DATA_W defaults shared with the instruction memory.
- One sub-module is natural: ifetch_ir_buf, the ir/ir_pc/ir_valid holding register with the valid/ready and flush logic.
- The PC and FSM stay in the top module.

## Test plan
- Reset, memory preloaded with words[0..3] = 32'h20000000, 1, 2, 3, ir_ready = 1: the sequence is ir_pc = 0, 1, 2, 3 on consecutive cycles, and inst_address = 0 during reset.
- ir_ready held low for 3 cycles after the first capture: ir stays 32'h20000000, ir_pc stays 0 and pc stays 1. Releasing ir_ready resumes with ir_pc = 1.
- Redirect to 16'h0040 while ir_valid = 1: the next cycle has ir_valid = 0, and the cycle after has ir_pc = 16'h0040.
- HALT_WORD at address 5: ir shows 32'hFFFF_FFFF with halted = 1, and no further address change. A redirect to 0 clears halted and refetches from 0.
- With IFETCH_BOUND_CHECK_EN defined, redirect to 16'd256: fault = 1, ir_valid = 0 and the state is FAULT. A redirect to 0 clears fault.
- Assert rst_n mid-stream with ir_valid = 1: all outputs are at their reset values immediately, without waiting for a clock edge.
